fft_cmul_pipe: RTL and testbench

//  Parametrised complex twiddle multiplier for R22SDF FFT stages: z = x*w (or x*conj(w)).

---
 rtl/fft_cmul_pipe.sv | 326 ++++++++++++++++++++++++++++++++
 tb/tb_fft_cmul_pipe.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_cmul_pipe.sv
`default_nettype none
//============================================================================
// Module      : fft_cmul_pipe
// Description : Complex twiddle multiplier z = x*w or x*conj(w) for R22SDF
//               FFT stages. Karatsuba form with three real products:
//                 f = c*(a-b), R = b*(c-d)+f, I = a*(c+d)-f
//               SHARED=0 : four-stage pipeline, one sample per clock.
//               SHARED=1 : one multiplier time-shared by a small FSM,
//                          one sample every five clocks.
//               The result is scaled by 2^-(TWIDDLE_WIDTH-1) with either
//               floor or round-half-to-even, then saturated to DATA_WIDTH.
// Ports       : clk_i/rst_n           clock, async active-low reset
//               in_valid_i/in_ready_o input handshake (ready=1 if SHARED=0)
//               conj_i, tag_i          per-sample conjugate flag and tag
//               x_re_i/x_im_i          signed data input
//               w_re_i/w_im_i          signed twiddle (Q1.TW-1)
//               out_valid_o            one-cycle pulse per result
//               tag_o, z_re_o/z_im_o   tag and signed result
//               ovf_o                  result saturated (re or im)
// Revision    : 1.0  initial single-clock release
//============================================================================
module fft_cmul_pipe #(
   parameter int DATA_WIDTH    = 25,
   parameter int TWIDDLE_WIDTH = 10,
   parameter int TAG_WIDTH     = 10,
   parameter int SHARED        = 0,
   parameter int RND_MODE      = 1
) (
   input  logic                     clk_i,
   input  logic                     rst_n,
   input  logic                     in_valid_i,
   output logic                     in_ready_o,
   input  logic                     conj_i,
   input  logic [TAG_WIDTH-1:0]     tag_i,
   input  logic [DATA_WIDTH-1:0]    x_re_i,
   input  logic [DATA_WIDTH-1:0]    x_im_i,
   input  logic [TWIDDLE_WIDTH-1:0] w_re_i,
   input  logic [TWIDDLE_WIDTH-1:0] w_im_i,
   output logic                     out_valid_o,
   output logic [TAG_WIDTH-1:0]     tag_o,
   output logic [DATA_WIDTH-1:0]    z_re_o,
   output logic [DATA_WIDTH-1:0]    z_im_o,
   output logic                     ovf_o
);

   localparam int C_DW  = DATA_WIDTH;
   localparam int C_TW  = TWIDDLE_WIDTH;
   localparam int C_DWD = C_TW + 1;          // conjugated w_im, holds +2^(TW-1)
   localparam int C_AW  = C_DW + 1;          // data pre-add width
   localparam int C_BW  = C_TW + 2;          // twiddle pre-add width
   localparam int C_PW  = C_DW + C_TW + 2;   // product / post-add width
   localparam int C_SH  = C_TW - 1;          // LSBs dropped by scaling
   localparam int C_QW  = C_PW - C_SH + 1;   // scaled value plus rounding carry

   localparam logic [C_SH-1:0]        C_HALF = {1'b1, {(C_SH-1){1'b0}}};
   localparam logic signed [C_QW-1:0] C_ONE  = C_QW'(1);
   localparam logic signed [C_QW-1:0] C_MAX  = {{(C_QW-C_DW+1){1'b0}}, {(C_DW-1){1'b1}}};
   localparam logic signed [C_QW-1:0] C_MIN  = {{(C_QW-C_DW+1){1'b1}}, {(C_DW-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MF   = 3'd1,
      S_MR   = 3'd2,
      S_MI   = 3'd3,
      S_RND  = 3'd4
   } state_t;

   // Scale, round and saturate one component. Returns {ovf, z}.
   function automatic logic [C_DW:0] round_sat(input logic signed [C_PW-1:0] v);
      logic signed [C_QW-1:0] q;
      logic [C_SH-1:0]        frac;
      logic [C_DW-1:0]        z;
      logic                   ovf;
      // Extra sign bit leaves room for the +1 of rounding without wrap.
      q    = {v[C_PW-1], v[C_PW-1:C_SH]};
      frac = v[C_SH-1:0];
      if (RND_MODE != 0) begin
         if ((frac > C_HALF) || ((frac == C_HALF) && q[0])) begin
            q = q + C_ONE;
         end
      end
      ovf = 1'b0;
      z   = q[C_DW-1:0];
      if (q > C_MAX) begin
         z   = C_MAX[C_DW-1:0];
         ovf = 1'b1;
      end else if (q < C_MIN) begin
         z   = C_MIN[C_DW-1:0];
         ovf = 1'b1;
      end
      return {ovf, z};
   endfunction

   // Input decode shared by both architectures.
   logic signed [C_DW-1:0]  w_a;
   logic signed [C_DW-1:0]  w_b;
   logic signed [C_TW-1:0]  w_c;
   logic signed [C_TW-1:0]  w_wim;
   logic signed [C_DWD-1:0] w_wim_ext;
   logic signed [C_DWD-1:0] w_d;

   assign w_a       = $signed(x_re_i);
   assign w_b       = $signed(x_im_i);
   assign w_c       = $signed(w_re_i);
   assign w_wim     = $signed(w_im_i);
   assign w_wim_ext = C_DWD'(w_wim);
   assign w_d       = conj_i ? -w_wim_ext : w_wim_ext;

   generate
      if (SHARED == 0) begin : g_pipe
         logic signed [C_AW-1:0] w_amb;
         logic signed [C_BW-1:0] w_cmd;
         logic signed [C_BW-1:0] w_cpd;
         logic [C_DW:0]          w_rs_re;
         logic [C_DW:0]          w_rs_im;

         // Stage valids: [0]=S1 pre-add, [1]=S2 mult, [2]=S3 post-add, [3]=S4 out
         logic [3:0]             r_vld;
         logic [TAG_WIDTH-1:0]   r1_tag, r2_tag, r3_tag, r4_tag;
         logic signed [C_AW-1:0] r1_amb;
         logic signed [C_BW-1:0] r1_cmd, r1_cpd;
         logic signed [C_DW-1:0] r1_a, r1_b;
         logic signed [C_TW-1:0] r1_c;
         logic signed [C_PW-1:0] r2_f, r2_pr, r2_pi;
         logic signed [C_PW-1:0] r3_r, r3_i;
         logic [C_DW-1:0]        r4_zr, r4_zi;
         logic                   r4_ovf;

         assign w_amb   = C_AW'(w_a) - C_AW'(w_b);
         assign w_cmd   = C_BW'(w_c) - C_BW'(w_d);
         assign w_cpd   = C_BW'(w_c) + C_BW'(w_d);
         assign w_rs_re = round_sat(r3_r);
         assign w_rs_im = round_sat(r3_i);

         // Each stage loads only when its predecessor holds a valid sample,
         // so z/tag/ovf hold the last result between pulses.
         always_ff @(posedge clk_i or negedge rst_n) begin
            if (!rst_n) begin
               r_vld  <= '0;
               r1_tag <= '0;
               r2_tag <= '0;
               r3_tag <= '0;
               r4_tag <= '0;
               r1_amb <= '0;
               r1_cmd <= '0;
               r1_cpd <= '0;
               r1_a   <= '0;
               r1_b   <= '0;
               r1_c   <= '0;
               r2_f   <= '0;
               r2_pr  <= '0;
               r2_pi  <= '0;
               r3_r   <= '0;
               r3_i   <= '0;
               r4_zr  <= '0;
               r4_zi  <= '0;
               r4_ovf <= 1'b0;
            end else begin
               r_vld <= {r_vld[2:0], in_valid_i};
               if (in_valid_i) begin
                  r1_amb <= w_amb;
                  r1_cmd <= w_cmd;
                  r1_cpd <= w_cpd;
                  r1_a   <= w_a;
                  r1_b   <= w_b;
                  r1_c   <= w_c;
                  r1_tag <= tag_i;
               end
               if (r_vld[0]) begin
                  r2_f   <= C_PW'(r1_c) * C_PW'(r1_amb);
                  r2_pr  <= C_PW'(r1_b) * C_PW'(r1_cmd);
                  r2_pi  <= C_PW'(r1_a) * C_PW'(r1_cpd);
                  r2_tag <= r1_tag;
               end
               if (r_vld[1]) begin
                  r3_r   <= r2_pr + r2_f;
                  r3_i   <= r2_pi - r2_f;
                  r3_tag <= r2_tag;
               end
               if (r_vld[2]) begin
                  r4_zr  <= w_rs_re[C_DW-1:0];
                  r4_zi  <= w_rs_im[C_DW-1:0];
                  r4_ovf <= w_rs_re[C_DW] | w_rs_im[C_DW];
                  r4_tag <= r3_tag;
               end
            end
         end

         assign in_ready_o  = 1'b1;
         assign out_valid_o = r_vld[3];
         assign tag_o       = r4_tag;
         assign z_re_o      = r4_zr;
         assign z_im_o      = r4_zi;
         assign ovf_o       = r4_ovf;
      end else begin : g_shared
         state_t                 r_state;
         state_t                 w_next;
         logic                   w_ready;
         logic signed [C_AW-1:0] w_s_amb;
         logic signed [C_BW-1:0] w_s_cmd;
         logic signed [C_BW-1:0] w_s_cpd;
         logic signed [C_AW-1:0] w_opx;
         logic signed [C_BW-1:0] w_opw;
         logic signed [C_PW-1:0] w_prod;
         logic [C_DW:0]          w_rs_re;
         logic [C_DW:0]          w_rs_im;

         logic signed [C_DW-1:0]  r_a, r_b;
         logic signed [C_TW-1:0]  r_c;
         logic signed [C_DWD-1:0] r_d;
         logic [TAG_WIDTH-1:0]    r_tag, r_tag_o;
         logic signed [C_PW-1:0]  r_f, r_acc_re, r_acc_im;
         logic [C_DW-1:0]         r_zr, r_zi;
         logic                    r_ovf;
         logic                    r_vld;

         assign w_s_amb = C_AW'(r_a) - C_AW'(r_b);
         assign w_s_cmd = C_BW'(r_c) - C_BW'(r_d);
         assign w_s_cpd = C_BW'(r_c) + C_BW'(r_d);
         assign w_prod  = C_PW'(w_opx) * C_PW'(w_opw);
         assign w_rs_re = round_sat(r_acc_re);
         assign w_rs_im = round_sat(r_acc_im);

         always_ff @(posedge clk_i or negedge rst_n) begin
            if (!rst_n) begin
               r_state <= S_IDLE;
            end else begin
               r_state <= w_next;
            end
         end

         // Next state, ready, and the operand pair fed to the one multiplier.
         always_comb begin
            w_next  = r_state;
            w_ready = 1'b0;
            w_opx   = w_s_amb;
            w_opw   = C_BW'(r_c);
            case (r_state)
               S_IDLE: begin
                  w_ready = 1'b1;
                  if (in_valid_i) begin
                     w_next = S_MF;
                  end
               end
               S_MF: begin
                  w_next = S_MR;
               end
               S_MR: begin
                  w_next = S_MI;
                  w_opx  = C_AW'(r_b);
                  w_opw  = w_s_cmd;
               end
               S_MI: begin
                  w_next = S_RND;
                  w_opx  = C_AW'(r_a);
                  w_opw  = w_s_cpd;
               end
               S_RND: begin
                  w_next = S_IDLE;
               end
               default: begin
                  w_next = S_IDLE;
               end
            endcase
         end

         always_ff @(posedge clk_i or negedge rst_n) begin
            if (!rst_n) begin
               r_a      <= '0;
               r_b      <= '0;
               r_c      <= '0;
               r_d      <= '0;
               r_tag    <= '0;
               r_tag_o  <= '0;
               r_f      <= '0;
               r_acc_re <= '0;
               r_acc_im <= '0;
               r_zr     <= '0;
               r_zi     <= '0;
               r_ovf    <= 1'b0;
               r_vld    <= 1'b0;
            end else begin
               r_vld <= 1'b0;
               case (r_state)
                  S_IDLE: begin
                     if (in_valid_i) begin
                        r_a   <= w_a;
                        r_b   <= w_b;
                        r_c   <= w_c;
                        r_d   <= w_d;
                        r_tag <= tag_i;
                     end
                  end
                  S_MF: begin
                     r_f <= w_prod;
                  end
                  S_MR: begin
                     r_acc_re <= w_prod + r_f;
                  end
                  S_MI: begin
                     r_acc_im <= w_prod - r_f;
                  end
                  S_RND: begin
                     r_zr    <= w_rs_re[C_DW-1:0];
                     r_zi    <= w_rs_im[C_DW-1:0];
                     r_ovf   <= w_rs_re[C_DW] | w_rs_im[C_DW];
                     r_tag_o <= r_tag;
                     r_vld   <= 1'b1;
                  end
                  default: begin
                  end
               endcase
            end
         end

         assign in_ready_o  = w_ready;
         assign out_valid_o = r_vld;
         assign tag_o       = r_tag_o;
         assign z_re_o      = r_zr;
         assign z_im_o      = r_zi;
         assign ovf_o       = r_ovf;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fft_cmul_pipe.sv
`default_nettype none
//============================================================================
// Module      : tb_fft_cmul_pipe
// Description : Self-checking bench for fft_cmul_pipe. Three instances share
//               one input stream: pipelined/convergent, pipelined/floor and
//               shared/convergent. Expected results come from a plain
//               complex-multiply reference model.
// Revision    : 1.0  initial release
//============================================================================
module tb_fft_cmul_pipe;
   localparam int DW  = 25;
   localparam int TW  = 10;
   localparam int TGW = 10;

   typedef struct {
      longint re;
      longint im;
      longint ovf;
      longint tag;
      int     due;
   } exp_t;

   logic           clk;
   logic           rst_n;
   logic           in_valid;
   logic           conj;
   logic [TGW-1:0] tag;
   logic [DW-1:0]  x_re, x_im;
   logic [TW-1:0]  w_re, w_im;

   logic p1_rdy, p1_v, p1_ovf, p0_rdy, p0_v, p0_ovf, s_rdy, s_v, s_ovf;
   logic [TGW-1:0] p1_tg, p0_tg, s_tg;
   logic [DW-1:0]  p1_zr, p1_zi, p0_zr, p0_zi, s_zr, s_zi;

   int total = 0;
   int bad   = 0;
   int cyc;

   // single-sample capture results
   longint lp, np, zr1, zi1, ov1, tg1, n0, zr0, zi0, ls, ns, zrs, zis, ovs, tgs;

   exp_t qp1[$], qp0[$], qs[$];

   fft_cmul_pipe #(.DATA_WIDTH(DW), .TWIDDLE_WIDTH(TW), .TAG_WIDTH(TGW),
                   .SHARED(0), .RND_MODE(1)) u_p1 (
      .clk_i(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(p1_rdy),
      .conj_i(conj), .tag_i(tag), .x_re_i(x_re), .x_im_i(x_im),
      .w_re_i(w_re), .w_im_i(w_im), .out_valid_o(p1_v), .tag_o(p1_tg),
      .z_re_o(p1_zr), .z_im_o(p1_zi), .ovf_o(p1_ovf));

   fft_cmul_pipe #(.DATA_WIDTH(DW), .TWIDDLE_WIDTH(TW), .TAG_WIDTH(TGW),
                   .SHARED(0), .RND_MODE(0)) u_p0 (
      .clk_i(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(p0_rdy),
      .conj_i(conj), .tag_i(tag), .x_re_i(x_re), .x_im_i(x_im),
      .w_re_i(w_re), .w_im_i(w_im), .out_valid_o(p0_v), .tag_o(p0_tg),
      .z_re_o(p0_zr), .z_im_o(p0_zi), .ovf_o(p0_ovf));

   fft_cmul_pipe #(.DATA_WIDTH(DW), .TWIDDLE_WIDTH(TW), .TAG_WIDTH(TGW),
                   .SHARED(1), .RND_MODE(1)) u_s1 (
      .clk_i(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(s_rdy),
      .conj_i(conj), .tag_i(tag), .x_re_i(x_re), .x_im_i(x_im),
      .w_re_i(w_re), .w_im_i(w_im), .out_valid_o(s_v), .tag_o(s_tg),
      .z_re_o(s_zr), .z_im_o(s_zi), .ovf_o(s_ovf));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string nm, input longint act, input longint exp);
      total++;
      assert (act === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", nm, act, exp);
      end
   endtask

   // Reference: exact complex product, scaled by 2^-(TW-1), rounded, clamped.
   function automatic longint scale(input longint v, input int rnd);
      longint q, rem;
      q   = v >>> (TW - 1);
      rem = v - q * (64'sd1 <<< (TW - 1));
      if (rnd != 0) begin
         if (rem > (64'sd1 <<< (TW - 2)) ||
             (rem == (64'sd1 <<< (TW - 2)) && (q & 1) != 0)) q = q + 1;
      end
      return q;
   endfunction

   function automatic exp_t model(input int rnd, input int due);
      exp_t   e;
      longint a, b, c, d, rr, ii, hi, lo;
      a  = longint'($signed(x_re));
      b  = longint'($signed(x_im));
      c  = longint'($signed(w_re));
      d  = longint'($signed(w_im));
      if (conj) d = -d;
      hi = (64'sd1 <<< (DW - 1)) - 1;
      lo = -(64'sd1 <<< (DW - 1));
      rr = scale(a * c - b * d, rnd);
      ii = scale(a * d + b * c, rnd);
      e.ovf = 0;
      if (rr > hi) begin rr = hi; e.ovf = 1; end
      if (rr < lo) begin rr = lo; e.ovf = 1; end
      if (ii > hi) begin ii = hi; e.ovf = 1; end
      if (ii < lo) begin ii = lo; e.ovf = 1; end
      e.re  = rr;
      e.im  = ii;
      e.tag = longint'(tag);
      e.due = due;
      return e;
   endfunction

   // One isolated sample into all three instances; records latency (edges
   // counted from the accepting edge = 1) and the output seen with each pulse.
   task automatic single(input longint xr, xi, wr, wi, input bit cj, input int tg);
      @(negedge clk);
      x_re = DW'(xr); x_im = DW'(xi); w_re = TW'(wr); w_im = TW'(wi);
      conj = cj; tag = TGW'(tg); in_valid = 1'b1;
      lp = -1; np = 0; n0 = 0; ls = -1; ns = 0;
      for (int n = 1; n <= 9; n++) begin
         @(posedge clk); #1;
         in_valid = 1'b0;
         if (p1_v) begin
            np++; lp = n; zr1 = $signed(p1_zr); zi1 = $signed(p1_zi);
            ov1 = p1_ovf; tg1 = p1_tg;
         end
         if (p0_v) begin
            n0++; zr0 = $signed(p0_zr); zi0 = $signed(p0_zi);
         end
         if (s_v) begin
            ns++; ls = n; zrs = $signed(s_zr); zis = $signed(s_zi);
            ovs = s_ovf; tgs = s_tg;
         end
      end
   endtask

   task automatic expect_single(input string nm, input longint re1, im1, ov,
                                input longint re0, im0, input longint tg);
      check({nm, " p lat"}, lp, 4);
      check({nm, " p pulses"}, np, 1);
      check({nm, " p re"}, zr1, re1);
      check({nm, " p im"}, zi1, im1);
      check({nm, " p ovf"}, ov1, ov);
      check({nm, " p tag"}, tg1, tg);
      check({nm, " p0 pulses"}, n0, 1);
      check({nm, " p0 re"}, zr0, re0);
      check({nm, " p0 im"}, zi0, im0);
      check({nm, " s lat"}, ls, 5);
      check({nm, " s pulses"}, ns, 1);
      check({nm, " s re"}, zrs, re1);
      check({nm, " s im"}, zis, im1);
      check({nm, " s ovf"}, ovs, ov);
      check({nm, " s tag"}, tgs, tg);
   endtask

   task automatic sb_cmp(input string nm, input logic v, input logic [DW-1:0] zr, zi,
                         input logic o, input logic [TGW-1:0] tg, input bit ev, input exp_t e);
      check({nm, " valid"}, longint'(v), longint'(ev));
      if (ev && v) begin
         check({nm, " re"}, longint'($signed(zr)), e.re);
         check({nm, " im"}, longint'($signed(zi)), e.im);
         check({nm, " ovf"}, longint'(o), e.ovf);
         check({nm, " tag"}, longint'(tg), e.tag);
      end
   endtask

   task automatic sb_step();
      exp_t e;
      bit   ev;
      e  = '{re: 0, im: 0, ovf: 0, tag: 0, due: 0};
      ev = (qp1.size() != 0) && (qp1[0].due == cyc);
      if (ev) e = qp1.pop_front();
      sb_cmp("rand p1", p1_v, p1_zr, p1_zi, p1_ovf, p1_tg, ev, e);
      ev = (qp0.size() != 0) && (qp0[0].due == cyc);
      if (ev) e = qp0.pop_front();
      sb_cmp("rand p0", p0_v, p0_zr, p0_zi, p0_ovf, p0_tg, ev, e);
      ev = (qs.size() != 0) && (qs[0].due == cyc);
      if (ev) e = qs.pop_front();
      sb_cmp("rand s", s_v, s_zr, s_zi, s_ovf, s_tg, ev, e);
   endtask

   longint big;
   int     idx, ocnt, spur;
   int     acc_cyc[3], out_cyc[3], low_cnt[3];
   longint out_tag[3];
   bit     rdy;

   initial begin
      rst_n = 1'b1; in_valid = 1'b0; conj = 1'b0; tag = '0;
      x_re = '0; x_im = '0; w_re = '0; w_im = '0;
      big = 64'sd1 <<< (DW - 1);
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      // reset state
      check("rst p valid", longint'(p1_v), 0);
      check("rst p z_re", longint'(p1_zr), 0);
      check("rst p tag", longint'(p1_tg), 0);
      check("rst p ovf", longint'(p1_ovf), 0);
      check("rst p ready", longint'(p1_rdy), 1);
      check("rst p0 ready", longint'(p0_rdy), 1);
      check("rst s ready", longint'(s_rdy), 1);
      check("rst s valid", longint'(s_v), 0);
      check("rst s z_im", longint'(s_zi), 0);
      rst_n = 1'b1;

      // basic product and latency
      single(1000, 0, 256, 0, 0, 3);
      expect_single("t1", 500, 0, 0, 500, 0, 3);

      // imaginary twiddle, with and without conjugate
      single(0, 1000, 0, 256, 0, 4);
      expect_single("t2 conj0", -500, 0, 0, -500, 0, 4);
      single(0, 1000, 0, 256, 1, 5);
      expect_single("t2 conj1", 500, 0, 0, 500, 0, 5);

      // rounding: x_re/2 with ties
      single(3, 0, 256, 0, 0, 6);
      expect_single("t3 +3", 2, 0, 0, 1, 0, 6);
      single(5, 0, 256, 0, 0, 7);
      expect_single("t3 +5", 2, 0, 0, 2, 0, 7);
      single(-3, 0, 256, 0, 0, 8);
      expect_single("t3 -3", -2, 0, 0, -2, 0, 8);
      single(-5, 0, 256, 0, 0, 9);
      expect_single("t3 -5", -2, 0, 0, -3, 0, 9);

      // saturation corners
      single(-big, -big, -512, 0, 0, 10);
      expect_single("t4 w=-1", big - 1, big - 1, 1, big - 1, big - 1, 10);
      single(-big, -big, 0, -512, 1, 11);
      expect_single("t4 conj", big - 1, -big, 1, big - 1, -big, 11);

      // shared: three samples, in_valid held high
      @(negedge clk);
      x_re = DW'(1000); x_im = '0; w_re = TW'(256); w_im = '0; conj = 1'b0;
      tag = TGW'(7); in_valid = 1'b1;
      idx = 0; ocnt = 0; low_cnt = '{0, 0, 0}; acc_cyc = '{0, 0, 0}; out_cyc = '{0, 0, 0};
      for (int n = 1; n <= 25; n++) begin
         rdy = s_rdy;
         if (in_valid && !rdy) low_cnt[idx]++;
         @(posedge clk); #1;
         if (in_valid && rdy) begin
            acc_cyc[idx] = n;
            idx++;
            if (idx == 3) in_valid = 1'b0;
            else tag = TGW'(7 + idx);
         end
         if (s_v) begin
            if (ocnt < 3) begin
               out_cyc[ocnt] = n;
               out_tag[ocnt] = s_tg;
            end
            ocnt++;
         end
         @(negedge clk);
      end
      check("t5 accepts", idx, 3);
      check("t5 outputs", ocnt, 3);
      check("t5 acc gap 1", acc_cyc[1] - acc_cyc[0], 5);
      check("t5 acc gap 2", acc_cyc[2] - acc_cyc[1], 5);
      check("t5 ready low 1", low_cnt[1], 4);
      check("t5 ready low 2", low_cnt[2], 4);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("t5 out lag %0d", i), out_cyc[i] - acc_cyc[i], 4);
         check($sformatf("t5 tag %0d", i), out_tag[i], 7 + i);
      end
      check("t5 last z", longint'($signed(s_zr)), 500);

      // reset while the shared FSM is in MR and the pipeline holds a sample
      single(1000, 0, 256, 0, 0, 12);
      @(negedge clk);
      x_re = DW'(2000); tag = TGW'(13); in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("t6 s z_re", longint'(s_zr), 0);
      check("t6 s ready", longint'(s_rdy), 1);
      check("t6 s tag", longint'(s_tg), 0);
      check("t6 p z_re", longint'(p1_zr), 0);
      check("t6 p valid", longint'(p1_v), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      spur = 0;
      for (int n = 0; n < 8; n++) begin
         @(posedge clk); #1;
         if (p1_v || p0_v || s_v) spur++;
      end
      check("t6 no pulse", spur, 0);
      single(-3, 0, 256, 0, 0, 14);
      expect_single("t6 after", -2, 0, 0, -2, 0, 14);

      // random stream: 1000 back-to-back, then with gaps
      @(negedge clk);
      cyc = 0;
      for (int i = 0; i < 1310; i++) begin
         sb_step();
         if (i < 1000) in_valid = 1'b1;
         else if (i < 1300) in_valid = ($urandom_range(0, 3) != 0);
         else in_valid = 1'b0;
         x_re = DW'($urandom); x_im = DW'($urandom);
         w_re = TW'($urandom); w_im = TW'($urandom);
         conj = 1'($urandom); tag = TGW'($urandom);
         if (in_valid) begin
            qp1.push_back(model(1, cyc + 4));
            qp0.push_back(model(0, cyc + 4));
            if (s_rdy) qs.push_back(model(1, cyc + 5));
         end
         @(posedge clk);
         cyc++;
         @(negedge clk);
      end
      check("rand p1 drained", qp1.size(), 0);
      check("rand p0 drained", qp0.size(), 0);
      check("rand s drained", qs.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
